// File: rtl/pos_sweep_unit_if.sv
// Bus bundle for pos_sweep_unit: table config port, direct-evaluation port and
// sweep stream port. The unit sits on the slave modport.
interface pos_sweep_unit_if #(
  parameter int N_INPUTS = 4
);
  logic                cfg_we;
  logic [N_INPUTS-1:0] cfg_addr;
  logic                cfg_data;
  logic [N_INPUTS-1:0] eval_in;
  logic                eval_out;
  logic                start;
  logic                busy;
  // sweep stream: a row moves when sweep_valid & sweep_ready are both high at a
  // rising edge; while valid is high and ready is low, idx/result are held stable
  logic                sweep_valid;
  logic                sweep_ready;
  logic [N_INPUTS-1:0] sweep_idx;
  logic                sweep_result;
  logic                done;
  logic [N_INPUTS:0]   zero_count;
  logic [1:0]          dbg_state;

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, eval_in, start, sweep_ready,
    output eval_out, busy, sweep_valid, sweep_idx, sweep_result, done,
           zero_count, dbg_state
  );

  modport master (
    output cfg_we, cfg_addr, cfg_data, eval_in, start, sweep_ready,
    input  eval_out, busy, sweep_valid, sweep_idx, sweep_result, done,
           zero_count, dbg_state
  );
endinterface

// File: rtl/pos_sweep_unit.sv
// Programmable product-of-sums function unit: F(x) = ~table[x], with a registered
// direct-evaluation path and a sweep engine that streams every row over valid/ready.
module pos_sweep_unit #(
  parameter int N_INPUTS = 4
) (
  input  logic            clk,
  input  logic            reset,
  pos_sweep_unit_if.slave bus
);
  localparam int                  ROWS     = 2 ** N_INPUTS;
  localparam logic [N_INPUTS-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ROWS-1:0]     table_q, table_d;
  logic                eval_out_q, eval_out_d;
  logic [N_INPUTS-1:0] idx_q, idx_d;
  logic [N_INPUTS:0]   zc_q, zc_d;
  logic                row_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      table_q    <= '0;
      eval_out_q <= 1'b0;
      idx_q      <= '0;
      zc_q       <= '0;
    end else begin
      state_q    <= state_d;
      table_q    <= table_d;
      eval_out_q <= eval_out_d;
      idx_q      <= idx_d;
      zc_q       <= zc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    table_d    = table_q;
    idx_d      = idx_q;
    zc_d       = zc_q;
    row_result = ~table_q[idx_q];
    // Reads the pre-write table, so a same-edge write shows up one cycle later.
    eval_out_d = ~table_q[bus.eval_in];

    // Table is frozen only during SWEEP; a write alongside start lands before row 0.
    if (bus.cfg_we && (state_q != SWEEP)) begin
      table_d[bus.cfg_addr] = bus.cfg_data;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SWEEP;
          idx_d   = '0;
          zc_d    = '0;
        end
      end
      SWEEP: begin
        if (bus.sweep_ready) begin
          if (!row_result) begin
            zc_d = zc_q + 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.eval_out     = eval_out_q;
  assign bus.busy         = (state_q == SWEEP);
  assign bus.sweep_valid  = (state_q == SWEEP);
  assign bus.sweep_idx    = idx_q;
  assign bus.sweep_result = (state_q == SWEEP) & row_result;
  assign bus.done         = (state_q == DONE);
  assign bus.zero_count   = zc_q;
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_pos_sweep_unit.sv
// Bench for pos_sweep_unit: N_INPUTS=4 instance checked through a sweep scoreboard
// plus direct-path checks; N_INPUTS=1 and 8 instances checked for full-maxterm sweeps.
module tb_pos_sweep_unit;
  logic clk;
  logic reset;
  logic rdy_rand;
  int   n_checks;
  int   n_errors;
  int   done_cnt;
  logic [4:0] exp_q[$];

  pos_sweep_unit_if #(.N_INPUTS(4)) b4 ();
  pos_sweep_unit_if #(.N_INPUTS(1)) b1 ();
  pos_sweep_unit_if #(.N_INPUTS(8)) b8 ();

  pos_sweep_unit #(.N_INPUTS(4)) u_dut4 (.clk(clk), .reset(reset), .bus(b4));
  pos_sweep_unit #(.N_INPUTS(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
  pos_sweep_unit #(.N_INPUTS(8)) u_dut8 (.clk(clk), .reset(reset), .bus(b8));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks (N_INPUTS=4 instance)
  task automatic cfg_write(input logic [3:0] addr, input logic data);
    b4.cfg_we   = 1'b1;
    b4.cfg_addr = addr;
    b4.cfg_data = data;
    tick();
    b4.cfg_we   = 1'b0;
  endtask

  task automatic start_sweep();
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] res, input int n);
    for (int i = 0; i < n; i++) begin
      logic [3:0] idx;
      idx = 4'(i);
      exp_q.push_back({idx, res[i]});
    end
  endtask

  task automatic wait_done(input int exp_zc, input bit chk_busy);
    int  busy_cnt;
    bit  seen;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (b4.done) begin
        seen = 1'b1;
        break;
      end
      if (b4.busy) busy_cnt++;
    end
    chk("done_seen", 32'(seen), 1);
    chk("zero_count", 32'(b4.zero_count), exp_zc);
    chk("rows_left", exp_q.size(), 0);
    if (chk_busy) chk("busy_cycles", busy_cnt, 16);
    @(negedge clk);
    chk("done_one_cycle", 32'(b4.done), 0);
    chk("zero_count_hold", 32'(b4.zero_count), exp_zc);
  endtask

  // ready driver for the N_INPUTS=4 stream
  initial begin
    b4.sweep_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      b4.sweep_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // scoreboard monitor: rows must match the queue head while valid, pop on handshake
  initial begin
    forever begin
      @(negedge clk);
      if (b4.done) done_cnt++;
      if (b4.sweep_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_row", 32'(b4.sweep_idx), -1);
        end else begin
          chk("sweep_idx", 32'(b4.sweep_idx), 32'(exp_q[0][4:1]));
          chk("sweep_result", 32'(b4.sweep_result), 32'(exp_q[0][0]));
          if (b4.sweep_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int d0;
    int hs;
    int ones;
    int bad_idx;
    bit seen;
    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;
    rdy_rand = 1'b0;
    reset = 1'b1;
    b4.cfg_we = 1'b0; b4.cfg_addr = '0; b4.cfg_data = 1'b0; b4.eval_in = '0; b4.start = 1'b0;
    b1.cfg_we = 1'b0; b1.cfg_addr = '0; b1.cfg_data = 1'b0; b1.eval_in = '0; b1.start = 1'b0;
    b1.sweep_ready = 1'b1;
    b8.cfg_we = 1'b0; b8.cfg_addr = '0; b8.cfg_data = 1'b0; b8.eval_in = '0; b8.start = 1'b0;
    b8.sweep_ready = 1'b1;
    tick(); tick(); tick();

    // reset state
    @(negedge clk);
    chk("rst_eval_out", 32'(b4.eval_out), 0);
    chk("rst_busy", 32'(b4.busy), 0);
    chk("rst_valid", 32'(b4.sweep_valid), 0);
    chk("rst_idx", 32'(b4.sweep_idx), 0);
    chk("rst_result", 32'(b4.sweep_result), 0);
    chk("rst_done", 32'(b4.done), 0);
    chk("rst_zero_count", 32'(b4.zero_count), 0);
    tick();
    reset = 1'b0;
    tick();

    // empty table: 16 rows of 1
    push_exp(16'hFFFF, 16);
    start_sweep();
    wait_done(0, 1'b1);

    // maxterms at 0,1,2,5,6,8,9,10,13,14 -> F=1 at 3,4,7,11,12,15
    cfg_write(4'd0, 1'b1);  cfg_write(4'd1, 1'b1);  cfg_write(4'd2, 1'b1);
    cfg_write(4'd5, 1'b1);  cfg_write(4'd6, 1'b1);  cfg_write(4'd8, 1'b1);
    cfg_write(4'd9, 1'b1);  cfg_write(4'd10, 1'b1); cfg_write(4'd13, 1'b1);
    cfg_write(4'd14, 1'b1);
    push_exp(16'h9898, 16);
    start_sweep();
    wait_done(10, 1'b1);

    // direct path
    b4.eval_in = 4'b0011;
    tick();
    @(negedge clk);
    chk("eval_0011", 32'(b4.eval_out), 1);
    b4.eval_in = 4'b0110;
    tick();
    @(negedge clk);
    chk("eval_0110", 32'(b4.eval_out), 0);
    b4.eval_in = 4'b0011;
    tick();
    cfg_write(4'd3, 1'b1);
    @(negedge clk);
    chk("eval_rbw_first", 32'(b4.eval_out), 1);
    tick();
    @(negedge clk);
    chk("eval_rbw_second", 32'(b4.eval_out), 0);
    cfg_write(4'd3, 1'b0);

    // random ready, with a write to row 0 during the sweep that must be ignored
    rdy_rand = 1'b1;
    push_exp(16'h9898, 16);
    start_sweep();
    tick(); tick(); tick();
    cfg_write(4'd0, 1'b0);
    wait_done(10, 1'b0);
    rdy_rand = 1'b0;
    b4.eval_in = 4'd0;
    tick();
    @(negedge clk);
    chk("row0_frozen", 32'(b4.eval_out), 0);

    // reset while idx 7 is presented
    tick();
    push_exp(16'h9898, 8);
    start_sweep();
    for (int i = 0; i < 7; i++) tick();
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_busy", 32'(b4.busy), 0);
    chk("midrst_valid", 32'(b4.sweep_valid), 0);
    chk("midrst_zero_count", 32'(b4.zero_count), 0);
    chk("midrst_idx", 32'(b4.sweep_idx), 0);
    chk("midrst_rows_left", exp_q.size(), 0);
    reset = 1'b0;
    tick(); tick(); tick();
    chk("midrst_no_done", done_cnt, d0);
    push_exp(16'hFFFF, 16);
    start_sweep();
    wait_done(0, 1'b1);

    // write and start on the same edge: row 0 already a maxterm
    push_exp(16'hFFFE, 16);
    b4.cfg_we   = 1'b1;
    b4.cfg_addr = 4'd0;
    b4.cfg_data = 1'b1;
    b4.start    = 1'b1;
    tick();
    b4.cfg_we   = 1'b0;
    b4.start    = 1'b0;
    wait_done(1, 1'b1);

    // N_INPUTS=1: every row a maxterm
    for (int i = 0; i < 2; i++) begin
      b1.cfg_we = 1'b1; b1.cfg_addr = 1'(i); b1.cfg_data = 1'b1;
      tick();
    end
    b1.cfg_we = 1'b0;
    b1.start  = 1'b1;
    tick();
    b1.start = 1'b0;
    hs = 0; ones = 0; bad_idx = 0; seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (b1.done) begin seen = 1'b1; break; end
      if (b1.sweep_valid && b1.sweep_ready) begin
        if (32'(b1.sweep_idx) != hs) bad_idx++;
        if (b1.sweep_result) ones++;
        hs++;
      end
    end
    chk("n1_done", 32'(seen), 1);
    chk("n1_rows", hs, 2);
    chk("n1_idx_order", bad_idx, 0);
    chk("n1_ones", ones, 0);
    chk("n1_zero_count", 32'(b1.zero_count), 2);

    // N_INPUTS=8: every row a maxterm
    tick();
    for (int i = 0; i < 256; i++) begin
      b8.cfg_we = 1'b1; b8.cfg_addr = 8'(i); b8.cfg_data = 1'b1;
      tick();
    end
    b8.cfg_we = 1'b0;
    b8.start  = 1'b1;
    tick();
    b8.start = 1'b0;
    hs = 0; ones = 0; bad_idx = 0; seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (b8.done) begin seen = 1'b1; break; end
      if (b8.sweep_valid && b8.sweep_ready) begin
        if (32'(b8.sweep_idx) != hs) bad_idx++;
        if (b8.sweep_result) ones++;
        hs++;
      end
    end
    chk("n8_done", 32'(seen), 1);
    chk("n8_rows", hs, 256);
    chk("n8_idx_order", bad_idx, 0);
    chk("n8_ones", ones, 0);
    chk("n8_zero_count", 32'(b8.zero_count), 256);

    // final report
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pos_sweep_unit.md
Name: pos_sweep_unit

Overview:
- Parametrised product-of-sums (maxterm) function unit.
- A run-time programmable maxterm table defines an N-input boolean function.
- Direct evaluation path with registered output.
- Sweep engine walks all 2^N input combinations and streams (index, result) over a valid/ready handshake, counting rows that evaluate to 0.
- Replaces hard-wired single-function POS blocks and their exhaustive-print benches.

Parameters:
N_INPUTS, 4, number of function inputs; legal range 1..8; table depth 2^N_INPUTS rows.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  synchronous, active-high.
cfg_we  in  1  write one table row.
cfg_addr  in  N_INPUTS  row index to write.
cfg_data  in  1  1 = row is a maxterm (function = 0 there); 0 = function = 1.
eval_in  in  N_INPUTS  direct-evaluation input vector, MSB = first variable.
eval_out  out  1  registered function value for eval_in.
start  in  1  request a full sweep.
busy  out  1  sweep in progress.
sweep_valid  out  1  sweep_idx/sweep_result valid.
sweep_ready  in  1  consumer accepts the current row.
sweep_idx  out  N_INPUTS  current row index.
sweep_result  out  1  function value at sweep_idx.
done  out  1  one-cycle pulse at sweep end.
zero_count  out  N_INPUTS+1  number of 0-rows seen in the current/last sweep.

Behaviour:
- Reset is synchronous, active-high, on the single clock clk. Reset values:
  - table all 0 (function constant 1);
  - eval_out=0, busy=0, sweep_valid=0, sweep_idx=0, sweep_result=0, done=0, zero_count=0;
  - FSM in IDLE.
- Table semantics: F(x) = NOT table[x]. The table is a 2^N-bit register.
- Config write:
  - On a clk edge with cfg_we=1 and busy=0: table[cfg_addr] <= cfg_data.
  - cfg_we is ignored while busy=1, so the table is frozen during a sweep.
- Direct path:
  - eval_out <= ~table[eval_in] every cycle; 1-cycle latency.
  - Read-before-write: a same-cycle write to the same row is visible on eval_out one cycle later than the write.
  - Active in all states.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE: busy=0, sweep_valid=0. start=1 -> SWEEP, with sweep_idx<=0 and zero_count<=0.
  - SWEEP:
    - busy=1, sweep_valid=1, sweep_result = ~table[sweep_idx] (combinational from the registered index).
    - Handshake when sweep_valid & sweep_ready. On handshake, zero_count increments if sweep_result=0.
    - Handshake with sweep_idx < 2^N-1: sweep_idx increments.
    - Handshake with sweep_idx = 2^N-1: -> DONE, sweep_idx wraps to 0.
    - sweep_ready=0: sweep_idx and sweep_result hold stable, with no timeout.
    - start is ignored while in SWEEP.
  - DONE: lasts one cycle. done=1, busy=0, sweep_valid=0, then -> IDLE. start in this cycle is ignored.
- zero_count:
  - Holds its final value until the next accepted start.
  - Maximum value is 2^N; the width is N_INPUTS+1, so there is no overflow.
- Reset mid-sweep: the FSM returns to IDLE on the next edge, all outputs and the table take their reset values, and no done pulse is emitted.
- Simultaneous start and cfg_we in IDLE: the write takes effect and the sweep starts on the same edge. Row 0 of the sweep sees the updated table.

Test Plan:
- Reset, then sweep with ready=1 and N_INPUTS=4 -> 16 consecutive handshakes, idx 0..15, all results 1. done pulses the cycle after idx 15, zero_count=0, busy is high for exactly 16 cycles.
- Program maxterms at rows 0,1,2,5,6,8,9,10,13,14, then sweep -> results 1 only at rows 3,4,7,11,12,15; zero_count=10.
- Same table, direct path: eval_in=4'b0011 -> eval_out=1 next cycle; eval_in=4'b0110 -> 0. Write row 3 to 1 while eval_in=3 -> eval_out shows 1 on the first cycle, 0 on the second.
- Sweep with sweep_ready toggling 0/1 randomly -> idx and result stable while ready=0, no row skipped or repeated. cfg_we to row 0 mid-sweep is ignored: a post-sweep read shows the unchanged table.
- Assert reset at idx 7 of a sweep -> next cycle busy=0, sweep_valid=0, zero_count=0, no done pulse. A follow-up sweep returns all results 1.
- N_INPUTS=1 and N_INPUTS=8 builds -> sweeps of 2 and 256 rows. With all rows programmed as maxterms, zero_count = 2 and 256 respectively, with no overflow.
